// File: rtl/button_pkg.sv
// button_pkg: shared FSM state type, timing helper and synchroniser depth for button_reader.
package button_pkg;
  typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_RELEASE} state_t;
  localparam int SYNC_STAGES = 2;
  function automatic int ms_to_cycles(input int clk_freq, input int ms);
    int c;
    c = clk_freq / 1000 * ms;
    return (c < 1) ? 1 : c;
  endfunction
endpackage

// File: rtl/button_channel.sv
// button_channel: one button: synchroniser, debounce FSM, press/release/long pulses (BTN_REPEAT_EN adds auto-repeat).
module button_channel
  import button_pkg::*;
#(
  parameter int DEB_CYC  = 5,
  parameter int LONG_CYC = 20,
  parameter int REP_CYC  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press,
  output logic rls,
  output logic lng
);
  localparam int DW = $clog2(DEB_CYC + 1);
  localparam int LW = $clog2(LONG_CYC + 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [DW-1:0] deb_cnt;
  logic [LW-1:0] hold_cnt;
  state_t state;
  logic s;
  assign s = sync[SYNC_STAGES-1];
`ifdef BTN_REPEAT_EN
  localparam int RW = $clog2(REP_CYC + 1);
  logic [RW-1:0] rep_cnt;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      sync     <= '0;
      state    <= IDLE;
      deb_cnt  <= '0;
      hold_cnt <= '0;
      level    <= 1'b0;
      press    <= 1'b0;
      rls      <= 1'b0;
      lng      <= 1'b0;
`ifdef BTN_REPEAT_EN
      rep_cnt  <= '0;
`endif
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], btn};
      press <= 1'b0;
      rls   <= 1'b0;
      lng   <= 1'b0;
      case (state)
        IDLE: if (s) begin
          state   <= DEB_PRESS;
          deb_cnt <= DW'(1);
        end
        DEB_PRESS: if (!s) begin
          state   <= IDLE;
          deb_cnt <= '0;
        end else if (deb_cnt >= DW'(DEB_CYC - 1)) begin
          state    <= HELD;
          level    <= 1'b1;
          press    <= 1'b1;
          hold_cnt <= '0;
        end else deb_cnt <= deb_cnt + DW'(1);
        HELD: begin
          if (hold_cnt != LW'(LONG_CYC)) begin
            hold_cnt <= hold_cnt + LW'(1);
            lng      <= hold_cnt == LW'(LONG_CYC - 1);
          end
          if (!s) begin
            state   <= DEB_RELEASE;
            deb_cnt <= DW'(1);
          end
        end
        default: if (s) state <= HELD;
        else if (deb_cnt >= DW'(DEB_CYC - 1)) begin
          state   <= IDLE;
          level   <= 1'b0;
          rls     <= 1'b1;
          deb_cnt <= '0;
        end else deb_cnt <= deb_cnt + DW'(1);
      endcase
`ifdef BTN_REPEAT_EN
      // repeat only runs once the long press has been reached; hold_cnt is frozen in DEB_RELEASE
      if (state == IDLE) rep_cnt <= '0;
      else if (state != DEB_PRESS && hold_cnt == LW'(LONG_CYC)) begin
        rep_cnt <= (rep_cnt >= RW'(REP_CYC - 1)) ? '0 : rep_cnt + RW'(1);
        if (rep_cnt >= RW'(REP_CYC - 1)) press <= 1'b1;
      end
`endif
    end
  end
endmodule

// File: rtl/button_reader.sv
// button_reader: NUM_BTNS debounced pushbutton channels; define BTN_REPEAT_EN for auto-repeat presses.
module button_reader
  import button_pkg::*;
#(
  parameter int CLK_FREQ      = 25_000_000,
  parameter int NUM_BTNS      = 4,
  parameter int DEBOUNCE_MS   = 20,
  parameter int LONG_PRESS_MS = 1000,
  parameter int REPEAT_MS     = 200
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BTNS-1:0] btn_in,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [NUM_BTNS-1:0] btn_release,
  output logic [NUM_BTNS-1:0] btn_long
);
  localparam int DEB_CYC  = ms_to_cycles(CLK_FREQ, DEBOUNCE_MS);
  localparam int LONG_CYC = ms_to_cycles(CLK_FREQ, LONG_PRESS_MS);
  localparam int REP_CYC  = ms_to_cycles(CLK_FREQ, REPEAT_MS);
  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
    button_channel #(.DEB_CYC(DEB_CYC), .LONG_CYC(LONG_CYC), .REP_CYC(REP_CYC)) u_ch (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn_in[i]),
      .level(btn_level[i]),
      .press(btn_press[i]),
      .rls  (btn_release[i]),
      .lng  (btn_long[i])
    );
  end
endmodule

// File: tb/tb_button_reader.sv
// tb_button_reader: directed checks of debounce timing, bounce rejection, long press, simultaneity and reset.
module tb_button_reader;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] btn_in, btn_level, btn_press, btn_release, btn_long;
  int tests = 0, fails = 0, cyc = 0;
`ifdef BTN_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif
  always #5 clk = ~clk;
  button_reader #(
    .CLK_FREQ(1000), .NUM_BTNS(4), .DEBOUNCE_MS(5), .LONG_PRESS_MS(20), .REPEAT_MS(4)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .btn_level(btn_level),
    .btn_press(btn_press), .btn_release(btn_release), .btn_long(btn_long)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic restart;
    rst = 1'b1;
    btn_in = '0;
    step;
    step;
    rst = 1'b0;
    cyc = 0;
    check("rst_level", btn_level, 0);
    check("rst_press", btn_press, 0);
    check("rst_release", btn_release, 0);
    check("rst_long", btn_long, 0);
  endtask
  initial begin
    restart;
    while (cyc < 30) begin
      step;
      check("clean_press", btn_press, (cyc == 17) ? 1 : 0);
      check("clean_level", btn_level, (cyc >= 17) ? 1 : 0);
      check("clean_release", btn_release, 0);
      if (cyc == 10) btn_in[0] = 1'b1;
    end
    restart;
    btn_in[1] = 1'b1;
    while (cyc < 25) begin
      step;
      check("bounce_press", btn_press, 0);
      check("bounce_level", btn_level, 0);
      check("bounce_release", btn_release, 0);
      if (cyc == 2 || cyc == 6) btn_in[1] = 1'b0;
      if (cyc == 4) btn_in[1] = 1'b1;
    end
    restart;
    btn_in[2] = 1'b1;
    while (cyc < 60) begin
      step;
      check("long_press", btn_press,
            (cyc == 7 || (REP && cyc >= 31 && cyc <= 47 && (cyc - 31) % 4 == 0)) ? 4 : 0);
      check("long_long", btn_long, (cyc == 27) ? 4 : 0);
      check("long_release", btn_release, (cyc == 47) ? 4 : 0);
      check("long_level", btn_level, (cyc >= 7 && cyc < 47) ? 4 : 0);
      if (cyc == 40) btn_in[2] = 1'b0;
    end
    restart;
    while (cyc < 20) begin
      step;
      check("simul_press", btn_press, (cyc == 12) ? 15 : 0);
      check("simul_level", btn_level, (cyc >= 12) ? 15 : 0);
      if (cyc == 5) btn_in = 4'b1111;
    end
    restart;
    btn_in[0] = 1'b1;
    while (cyc < 35) begin
      step;
      check("rstmid_press", btn_press, (cyc == 7 || cyc == 28) ? 1 : 0);
      check("rstmid_level", btn_level, ((cyc >= 7 && cyc < 21) || cyc >= 28) ? 1 : 0);
      check("rstmid_release", btn_release, 0);
      check("rstmid_long", btn_long, 0);
      if (cyc == 20) rst = 1'b1;
      if (cyc == 21) rst = 1'b0;
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
